// File: rtl/qam_mixer.sv
// Symbol mapper/mixer: maps QPSK or Gray-coded 16-QAM symbols to I/Q amplitudes,
// holds each for SPS cycles and outputs amp_i*lo_cos + amp_q*lo_sin.
module qam_mixer #(
    parameter int LO_W  = 9,
    parameter int SPS   = 16,
    parameter int CNT_W = 16,
    localparam int OUT_W = LO_W + 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LO_W-1:0]  lo_cos,
    input  logic [LO_W-1:0]  lo_sin,
    input  logic             mode,
    input  logic             sym_valid,
    input  logic [3:0]       sym_data,
    output logic             sym_ready,
    output logic [OUT_W-1:0] qam_out,
    output logic             sym_active,
    output logic             underrun,
    output logic [CNT_W-1:0] sym_count
);

    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SPS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                  state_reg;
    logic [CW-1:0]           cnt_reg;
    logic signed [2:0]       amp_reg  [2];
    logic signed [2:0]       amp_next [2];
    logic signed [OUT_W-1:0] lo_ext   [2];
    logic signed [OUT_W-1:0] term     [2];
    logic signed [OUT_W-1:0] qam_reg;
    logic signed [OUT_W-1:0] qam_next;
    logic                    underrun_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    cnt_zero;
    logic                    accept;

    function automatic logic signed [2:0] gray_amp(input logic [1:0] pair);
        case (pair)
            2'b00:   gray_amp = -3'sd3;
            2'b01:   gray_amp = -3'sd1;
            2'b11:   gray_amp = 3'sd1;
            default: gray_amp = 3'sd3;
        endcase
    endfunction

    function automatic logic signed [2:0] qpsk_amp(input logic b);
        qpsk_amp = b ? 3'sd1 : -3'sd1;
    endfunction

    // cnt only reaches zero in the last cycle of a symbol, and idles at zero.
    assign cnt_zero   = (cnt_reg == '0);
    assign sym_ready  = (state_reg == IDLE) || cnt_zero;
    assign accept     = sym_valid && sym_ready;
    assign sym_active = (state_reg == ACTIVE);

    assign lo_ext[0] = $signed({{3{lo_cos[LO_W-1]}}, lo_cos});
    assign lo_ext[1] = $signed({{3{lo_sin[LO_W-1]}}, lo_sin});

    // Axis 0 is I (QPSK bit 1, 16-QAM pair [3:2]); axis 1 is Q (bit 0, pair [1:0]).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            logic       qpsk_bit;
            logic [1:0] qam_pair;

            assign qpsk_bit     = sym_data[1-gi];
            assign qam_pair     = sym_data[3-2*gi -: 2];
            assign amp_next[gi] = mode ? gray_amp(qam_pair) : qpsk_amp(qpsk_bit);
            // Full product fits in OUT_W, so computing modulo 2^OUT_W is exact.
            assign term[gi]     = $signed({{LO_W{amp_reg[gi][2]}}, amp_reg[gi]}) * lo_ext[gi];
        end
    endgenerate

    assign qam_next = (state_reg == ACTIVE) ? (term[0] + term[1]) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            qam_reg      <= '0;
            underrun_reg <= 1'b0;
            count_reg    <= '0;
            for (int i = 0; i < 2; i++) begin
                amp_reg[i] <= '0;
            end
        end else begin
            qam_reg      <= qam_next;
            underrun_reg <= 1'b0;
            if (accept) begin
                for (int i = 0; i < 2; i++) begin
                    amp_reg[i] <= amp_next[i];
                end
                cnt_reg   <= CNT_LOAD;
                state_reg <= ACTIVE;
                count_reg <= count_reg + 1'b1;
            end else if (state_reg == ACTIVE) begin
                if (cnt_zero) begin
                    state_reg    <= IDLE;
                    underrun_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg - CW'(1);
                end
            end
        end
    end

    assign qam_out   = qam_reg;
    assign underrun  = underrun_reg;
    assign sym_count = count_reg;

endmodule

// File: tb/tb_qam_mixer.sv
// Scoreboard bench for qam_mixer: an SPS=4 instance and an SPS=1 instance with a
// narrow symbol counter, both checked every cycle against a symbol-level model.
module tb_qam_mixer;

    localparam int LO_W  = 9;
    localparam int OUT_W = LO_W + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [LO_W-1:0]  lo_cos, lo_sin;
    logic             mode;
    logic             valid0, valid1;
    logic [3:0]       data0, data1;

    logic             ready0, ready1;
    logic signed [OUT_W-1:0] qam0, qam1;
    logic             act0, act1;
    logic             und0, und1;
    logic [15:0]      count0;
    logic [3:0]       count1;

    qam_mixer #(.LO_W(LO_W), .SPS(4), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .lo_cos(lo_cos), .lo_sin(lo_sin), .mode(mode),
        .sym_valid(valid0), .sym_data(data0), .sym_ready(ready0), .qam_out(qam0),
        .sym_active(act0), .underrun(und0), .sym_count(count0)
    );

    qam_mixer #(.LO_W(LO_W), .SPS(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .lo_cos(lo_cos), .lo_sin(lo_sin), .mode(mode),
        .sym_valid(valid1), .sym_data(data1), .sym_ready(ready1), .qam_out(qam1),
        .sym_active(act1), .underrun(und1), .sym_count(count1)
    );

    typedef struct {
        int qam;
        int und;
        int act;
        int rdy;
        int cnt;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Reference model: each accepted symbol yields SPS output samples.
    int sps_of[2]   = '{4, 1};
    int cmod[2]     = '{65536, 16};
    int qpsk_lut[2] = '{-1, 1};
    int gray_lut[4] = '{-3, -1, 3, 1};
    int left[2];
    int ai[2];
    int aq[2];
    int mcnt[2];

    exp_t       m_e;
    int         m_lc, m_ls;
    bit         m_v, m_acc;
    logic [3:0] m_d;

    always @(posedge clk) begin
        m_lc = $signed(lo_cos);
        m_ls = $signed(lo_sin);
        for (int u = 0; u < 2; u++) begin
            m_v   = (u == 0) ? valid0 : valid1;
            m_d   = (u == 0) ? data0 : data1;
            m_acc = !rst && m_v && (left[u] <= 1);
            m_e.qam = (!rst && left[u] > 0) ? (ai[u] * m_lc + aq[u] * m_ls) : 0;
            m_e.und = (!rst && left[u] == 1 && !m_acc) ? 1 : 0;
            if (rst) begin
                left[u] = 0;
                ai[u]   = 0;
                aq[u]   = 0;
                mcnt[u] = 0;
            end else if (m_acc) begin
                if (mode) begin
                    ai[u] = gray_lut[m_d[3:2]];
                    aq[u] = gray_lut[m_d[1:0]];
                end else begin
                    ai[u] = qpsk_lut[m_d[1]];
                    aq[u] = qpsk_lut[m_d[0]];
                end
                left[u] = sps_of[u];
                mcnt[u] = (mcnt[u] + 1) % cmod[u];
                $display("accept dut%0d mode=%0d data=%b amp_i=%0d amp_q=%0d count=%0d t=%0t",
                         u, mode, m_d, ai[u], aq[u], mcnt[u], $time);
            end else if (left[u] > 0) begin
                left[u] = left[u] - 1;
            end
            m_e.act = (left[u] > 0) ? 1 : 0;
            m_e.rdy = (left[u] <= 1) ? 1 : 0;
            m_e.cnt = mcnt[u];
            if (u == 0) sbq0.push_back(m_e);
            else        sbq1.push_back(m_e);
        end
    end

    task automatic cmp(input int u, input string name, input int got, input int exp);
        assert_cnt++;
        if (got != exp) begin
            fail_cnt++;
            $display("FAIL dut%0d %s: got %0d expected %0d at %0t", u, name, got, exp, $time);
        end
    endtask

    task automatic check(input int u, input exp_t e, input int q, input int un,
                         input int ac, input int rd, input int c);
        cmp(u, "qam_out", q, e.qam);
        cmp(u, "underrun", un, e.und);
        cmp(u, "sym_active", ac, e.act);
        cmp(u, "sym_ready", rd, e.rdy);
        cmp(u, "sym_count", c, e.cnt);
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (sbq0.size() > 0) begin
            mon_e = sbq0.pop_front();
            check(0, mon_e, int'(qam0), int'(und0), int'(act0), int'(ready0), int'(count0));
        end
        if (sbq1.size() > 0) begin
            mon_e = sbq1.pop_front();
            check(1, mon_e, int'(qam1), int'(und1), int'(act1), int'(ready1), int'(count1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one symbol to dut0 and return just after the edge that accepted it.
    task automatic send0(input logic m, input logic [3:0] d);
        bit rdy;
        int guard;
        mode   = m;
        data0  = d;
        valid0 = 1'b1;
        guard  = 0;
        do begin
            rdy = ready0;
            step();
            guard++;
        end while (!rdy && guard < 12);
        if (!rdy) begin
            assert_cnt++;
            fail_cnt++;
            $display("FAIL dut0 accept timeout: got ready=0 expected ready=1 within 12 cycles at %0t", $time);
        end
    endtask

    initial begin
        rst    = 1'b1;
        lo_cos = 9'd100;
        lo_sin = 9'd50;
        mode   = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        data0  = 4'd0;
        data1  = 4'd0;
        step();
        step();
        rst = 1'b0;
        step();

        // QPSK single symbol, then all four points back-to-back
        send0(1'b0, 4'b0011);
        valid0 = 1'b0;
        repeat (6) step();
        for (int d = 0; d < 4; d++) send0(1'b0, 4'(d));
        valid0 = 1'b0;
        repeat (6) step();

        // 16-QAM points and extremes
        send0(1'b1, 4'b1000);
        valid0 = 1'b0;
        repeat (6) step();
        send0(1'b1, 4'b0010);
        send0(1'b1, 4'b0111);
        valid0 = 1'b0;
        repeat (6) step();
        lo_cos = 9'h100;
        lo_sin = 9'h100;
        send0(1'b1, 4'b1010);
        valid0 = 1'b0;
        repeat (5) step();
        lo_cos = 9'd255;
        lo_sin = 9'd255;
        send0(1'b1, 4'b0000);
        valid0 = 1'b0;
        repeat (5) step();
        lo_cos = 9'd100;
        lo_sin = 9'd50;

        // Back-to-back with mode and data changing while the previous symbol plays
        for (int i = 0; i < 6; i++) send0(1'(i % 2), 4'($urandom));
        valid0 = 1'b0;
        repeat (6) step();

        // Reset two cycles into a symbol, then reset racing an accept in IDLE
        send0(1'b0, 4'b0110);
        valid0 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        valid0 = 1'b1;
        rst    = 1'b1;
        step();
        rst    = 1'b0;
        valid0 = 1'b0;
        repeat (3) step();

        // SPS=1 with valid held high: a new symbol every cycle, counter wraps
        valid1 = 1'b1;
        repeat (40) begin
            data1 = 4'($urandom);
            mode  = 1'($urandom);
            step();
        end
        valid1 = 1'b0;
        repeat (3) step();

        // Randomized traffic on both instances, including changing LO samples
        repeat (600) begin
            lo_cos = 9'($urandom);
            lo_sin = 9'($urandom);
            mode   = 1'($urandom);
            valid0 = ($urandom % 4) != 0;
            data0  = 4'($urandom);
            valid1 = ($urandom % 3) != 0;
            data1  = 4'($urandom);
            rst    = ($urandom % 97) == 0;
            step();
        end
        rst    = 1'b0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
